// File: rtl/aes_encipher_top.sv
// Iterative AES-128/256 encryption core: on-chip key expansion into a round-key memory,
// four-cycle SubBytes through one shared external 32-bit S-box, then one cycle of ShiftRows/MixColumns/AddRoundKey.
module aes_encipher_top #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic [255:0] key,
    input  logic [127:0] block,
    output logic         ready,
    output logic         key_ready,
    output logic [127:0] result,
    output logic         result_valid,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
            $fatal(1, "aes_encipher_top: KEY_BITS must be 128 or 256");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT_ARK, SUB, MIX} state_t;

    state_t       fsm;
    state_t       fsm_nxt;
    logic [31:0]  rk_mem [NW];
    logic [5:0]   wcnt;
    logic [7:0]   rcon;
    logic [127:0] st;
    logic [3:0]   round;
    logic [1:0]   col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    // Byte (row r, column c) sits at index 4c+r; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        case (c)
            2'd0:    return s[127:96];
            2'd1:    return s[95:64];
            2'd2:    return s[63:32];
            default: return s[31:0];
        endcase
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] w);
        logic [127:0] o;
        o = s;
        case (c)
            2'd0:    o[127:96] = w;
            2'd1:    o[95:64]  = w;
            2'd2:    o[63:32]  = w;
            default: o[31:0]   = w;
        endcase
        return o;
    endfunction

    logic [5:0]   rk_base;
    logic [127:0] round_key;
    logic [127:0] mix_out;

    assign rk_base   = {round, 2'b00};
    assign round_key = {rk_mem[rk_base], rk_mem[rk_base + 6'd1],
                        rk_mem[rk_base + 6'd2], rk_mem[rk_base + 6'd3]};
    assign mix_out   = (round == 4'(NR)) ? (shift_rows(st) ^ round_key)
                                         : (mix_columns(shift_rows(st)) ^ round_key);

    // Key schedule: one word per KEYEXP cycle; the cycle with wcnt == NW only flags completion.
    logic [31:0] w_prev, w_back, ke_temp, ke_word;
    logic        ke_rot, ke_sub, ke_last;

    assign w_prev  = rk_mem[wcnt - 6'd1];
    assign w_back  = rk_mem[wcnt - 6'(NK)];
    assign ke_last = (wcnt == 6'(NW));
    assign ke_rot  = ((wcnt & 6'(NK - 1)) == 6'd0);
    assign ke_sub  = (NK == 8) && (wcnt[2:0] == 3'd4);
    assign ke_temp = ke_rot ? (new_sboxw ^ {rcon, 24'h000000}) :
                     ke_sub ? new_sboxw : w_prev;
    assign ke_word = w_back ^ ke_temp;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE: begin
                if (init) begin
                    fsm_nxt = KEYEXP;
                end else if (next && key_ready) begin
                    fsm_nxt = INIT_ARK;
                end
            end
            KEYEXP:   if (ke_last) fsm_nxt = IDLE;
            INIT_ARK: fsm_nxt = SUB;
            SUB:      if (col == 2'd3) fsm_nxt = MIX;
            MIX:      fsm_nxt = (round == 4'(NR)) ? IDLE : SUB;
            default:  fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (fsm == IDLE);
        sboxw = '0;
        case (fsm)
            KEYEXP: begin
                if (!ke_last && ke_rot) begin
                    sboxw = {w_prev[23:0], w_prev[31:24]};
                end else if (!ke_last && ke_sub) begin
                    sboxw = w_prev;
                end
            end
            SUB:     sboxw = get_col(st, col);
            default: sboxw = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_ready    <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            wcnt         <= '0;
            rcon         <= '0;
            round        <= '0;
            col          <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (init) begin
                        key_ready <= 1'b0;
                        wcnt      <= 6'(NK);
                        rcon      <= 8'h01;
                    end else if (next && key_ready) begin
                        result_valid <= 1'b0;
                        round        <= '0;
                    end
                end
                KEYEXP: begin
                    if (ke_last) begin
                        key_ready <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 6'd1;
                        if (ke_rot) rcon <= xtime(rcon);
                    end
                end
                INIT_ARK: begin
                    round <= 4'd1;
                    col   <= 2'd0;
                end
                SUB: col <= col + 2'd1;
                MIX: begin
                    if (round == 4'(NR)) begin
                        result       <= mix_out;
                        result_valid <= 1'b1;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath storage carries no reset; key_ready gates every use of the round keys.
    // All eight key words are loaded; for AES-128 words 4..7 are overwritten during expansion.
    always_ff @(posedge clk) begin
        case (fsm)
            IDLE: begin
                if (init) begin
                    rk_mem[0] <= key[255:224];
                    rk_mem[1] <= key[223:192];
                    rk_mem[2] <= key[191:160];
                    rk_mem[3] <= key[159:128];
                    rk_mem[4] <= key[127:96];
                    rk_mem[5] <= key[95:64];
                    rk_mem[6] <= key[63:32];
                    rk_mem[7] <= key[31:0];
                end else if (next && key_ready) begin
                    st <= block;
                end
            end
            KEYEXP:   if (!ke_last) rk_mem[wcnt] <= ke_word;
            INIT_ARK: st <= st ^ round_key;
            SUB:      st <= put_col(st, col, new_sboxw);
            MIX:      st <= mix_out;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_aes_encipher_top.sv
// Bench for aes_encipher_top: one AES-128 and one AES-256 instance, each fed by a GF(2^8) S-box
// model, checked against FIPS-197 vectors and a textbook AES reference on random keys/blocks.
module tb_aes_encipher_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n   [2];
    logic         init_s    [2];
    logic         next_s    [2];
    logic [255:0] key_s     [2];
    logic [127:0] block_s   [2];
    logic         ready_s   [2];
    logic         key_ready_s [2];
    logic [127:0] result_s  [2];
    logic         rv_s      [2];
    logic [31:0]  sboxw_s   [2];
    logic [31:0]  nsbox_s   [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [255:0] cur_key [2];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // Multiplicative inverse as b^254, then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk,
                                             input logic [127:0] pt);
        logic [31:0] w [60];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc;
        logic [31:0] tmp;
        logic [127:0] o;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[q + 4*c] = s[q + 4*((c + q) % 4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end
                for (int i = 0; i < 16; i++) t[i] = s[i];
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    assign nsbox_s[0] = subw(sboxw_s[0]);
    assign nsbox_s[1] = subw(sboxw_s[1]);

    aes_encipher_top #(.KEY_BITS(128)) u128 (
        .clk(clk), .reset_n(reset_n[0]), .init(init_s[0]), .next(next_s[0]),
        .key(key_s[0]), .block(block_s[0]), .ready(ready_s[0]), .key_ready(key_ready_s[0]),
        .result(result_s[0]), .result_valid(rv_s[0]), .sboxw(sboxw_s[0]), .new_sboxw(nsbox_s[0])
    );

    aes_encipher_top #(.KEY_BITS(256)) u256 (
        .clk(clk), .reset_n(reset_n[1]), .init(init_s[1]), .next(next_s[1]),
        .key(key_s[1]), .block(block_s[1]), .ready(ready_s[1]), .key_ready(key_ready_s[1]),
        .result(result_s[1]), .result_valid(rv_s[1]), .sboxw(sboxw_s[1]), .new_sboxw(nsbox_s[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_idle_reset(input int d, input string nm);
        chk({nm, " ready"}, 256'(ready_s[d]), 256'd1);
        chk({nm, " key_ready"}, 256'(key_ready_s[d]), 256'd0);
        chk({nm, " result_valid"}, 256'(rv_s[d]), 256'd0);
        chk({nm, " result"}, 256'(result_s[d]), 256'd0);
        chk({nm, " sboxw"}, 256'(sboxw_s[d]), 256'd0);
    endtask

    // Optional disturbance: init+next pulse (with a different key) while the block is busy.
    task automatic run_init(input int d, input logic [255:0] k, input int lat,
                            input bit disturb, input string nm);
        int cnt;
        key_s[d]  = k;
        init_s[d] = 1'b1;
        tick();
        init_s[d] = 1'b0;
        key_s[d]  = ~k;
        cur_key[d] = k;
        cnt = 0;
        while (key_ready_s[d] !== 1'b1 && cnt < 200) begin
            init_s[d] = disturb && (cnt == 5);
            next_s[d] = disturb && (cnt == 5);
            tick();
            cnt++;
        end
        init_s[d] = 1'b0;
        next_s[d] = 1'b0;
        chk({nm, " key_ready latency"}, 256'(cnt), 256'(lat));
        chk({nm, " ready after keyexp"}, 256'(ready_s[d]), 256'd1);
    endtask

    task automatic run_next(input int d, input logic [127:0] blk, input logic [127:0] exp,
                            input int lat, input bit disturb, input string nm);
        int cnt;
        block_s[d] = blk;
        next_s[d]  = 1'b1;
        tick();
        next_s[d]  = 1'b0;
        block_s[d] = ~blk;
        cnt = 0;
        while (rv_s[d] !== 1'b1 && cnt < 300) begin
            if (cnt == 3) chk({nm, " ready while busy"}, 256'(ready_s[d]), 256'd0);
            init_s[d] = disturb && (cnt == 10 || cnt == 30);
            next_s[d] = disturb && (cnt == 10 || cnt == 20);
            key_s[d]  = {$urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            cnt++;
        end
        init_s[d] = 1'b0;
        next_s[d] = 1'b0;
        chk({nm, " result_valid latency"}, 256'(cnt), 256'(lat));
        chk({nm, " result"}, 256'(result_s[d]), 256'(exp));
        chk({nm, " ready after block"}, 256'(ready_s[d]), 256'd1);
    endtask

    typedef struct {
        int           d;
        logic [255:0] key;
        logic [127:0] blk;
        logic [127:0] ct;
        int           klat;
        int           elat;
    } vec_t;

    vec_t vt [3];

    initial begin
        logic [255:0] k;
        logic [127:0] b;
        int           d;
        int           busy;
        int           rv_seen;
        int           cnt;

        vt[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32, 41, 51};
        vt[1] = '{1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h00112233445566778899aabbccddeeff,
                  128'h8ea2b7ca516745bfeafc49904b496089, 53, 71};
        vt[2] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 41, 51};

        for (int i = 0; i < 2; i++) begin
            reset_n[i] = 1'b0;
            init_s[i]  = 1'b0;
            next_s[i]  = 1'b0;
            key_s[i]   = '0;
            block_s[i] = '0;
            cur_key[i] = '0;
        end
        tick();
        tick();
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        chk_idle_reset(0, "reset128");
        chk_idle_reset(1, "reset256");

        // next before any init is dropped
        block_s[1] = 128'h0123456789abcdef0123456789abcdef;
        next_s[1]  = 1'b1;
        tick();
        next_s[1]  = 1'b0;
        tick();
        chk("next before init ready", 256'(ready_s[1]), 256'd1);
        chk("next before init sboxw", 256'(sboxw_s[1]), 256'd0);

        // init+next together: expansion only, no encryption afterwards
        key_s[1]  = vt[1].key;
        init_s[1] = 1'b1;
        next_s[1] = 1'b1;
        tick();
        init_s[1] = 1'b0;
        next_s[1] = 1'b0;
        cnt = 0;
        while (key_ready_s[1] !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("init+next key_ready latency", 256'(cnt), 256'd53);
        rv_seen = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (rv_s[1] !== 1'b0) rv_seen++;
        end
        chk("init+next result_valid cycles", 256'(rv_seen), 256'd0);

        for (int i = 0; i < 3; i++) begin
            run_init(vt[i].d, vt[i].key, vt[i].klat, i == 0, $sformatf("vec%0d", i));
            run_next(vt[i].d, vt[i].blk, vt[i].ct, vt[i].elat, i == 0, $sformatf("vec%0d", i));
        end

        // Key reuse, second block issued in the cycle result_valid rises
        run_next(0, vt[2].blk, vt[2].ct, 51, 1'b0, "reuse1");
        run_next(0, vt[2].blk, vt[2].ct, 51, 1'b0, "reuse2");

        for (int it = 0; it < 8; it++) begin
            d = it % 2;
            if (it < 2 || $urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 8; j++) k[255 - 32*j -: 32] = $urandom();
                run_init(d, k, d ? 53 : 41, 1'b0, $sformatf("rnd%0d", it));
            end
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_next(d, b, aes_ref(cur_key[d], d ? 8 : 4, b), d ? 71 : 51, 1'b0,
                     $sformatf("rnd%0d", it));
        end

        // Reset in round 5 of an encryption
        block_s[0] = vt[2].blk;
        next_s[0]  = 1'b1;
        tick();
        next_s[0]  = 1'b0;
        for (int i = 0; i < 23; i++) tick();
        reset_n[0] = 1'b0;
        tick();
        reset_n[0] = 1'b1;
        chk_idle_reset(0, "midreset");
        next_s[0] = 1'b1;
        tick();
        next_s[0] = 1'b0;
        busy = 0;
        rv_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (ready_s[0] !== 1'b1) busy++;
            if (rv_s[0] !== 1'b0) rv_seen++;
        end
        chk("post-reset next busy cycles", 256'(busy), 256'd0);
        chk("post-reset next result_valid", 256'(rv_seen), 256'd0);
        run_init(0, vt[2].key, 41, 1'b0, "recover");
        run_next(0, vt[2].blk, vt[2].ct, 51, 1'b0, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
